spi_segment_rx: RTL
===================

// Module: spi_segment_rx
// PURPOSE
//  SPI mode-0 slave front end for the segment controller. It sits between the SPI pins and the
//  uo_out segment drive. Samples SCLK/CS_N/MOSI in the clk domain and decodes 16-bit frames into two
//  registers (segment pattern, control), then drives the registered 8-bit segment bus. Supports readback on MISO.
// PARAMETERS
//  SYNC_STAGES  2     synchroniser depth for spi_sclk, spi_cs_n, spi_mosi (>=2)
//  SEG_RST      8'h00 reset value of segment register
//  CTRL_RST     8'h01 reset value of control register (display enabled, not inverted)
// PORTS
//  clk          in   1  system clock; must run >= 8x SCLK
//  rst_n        in   1  synchronous, active-low reset
//  spi_sclk     in   1  SPI clock (async), idle low
//  spi_cs_n     in   1  SPI chip select (async), active low
//  spi_mosi     in   1  SPI data in, MSB first
//  spi_miso     out  1  SPI data out, MSB first
//  spi_miso_oe  out  1  1 while CS_N (synchronised) is low
//  seg_out      out  8  segment drive {dp,g,f,e,d,c,b,a}, registered
//  frame_valid  out  1  1-clk pulse: complete 16-bit frame decoded
//  frame_err    out  1  1-clk pulse: CS_N rose with 1..15 bits received
// BEHAVIOUR
//  - Reset (rst_n low at clk edge): seg_reg=SEG_RST, ctrl_reg=CTRL_RST, seg_out=8'h00, spi_miso=0,
//    spi_miso_oe=0, frame_valid=0, frame_err=0, bit_cnt=0, shift=0. Reset mid-frame discards the
//    frame. Decoding resumes at the next CS_N falling edge.
//  - Sampling: all three inputs pass through SYNC_STAGES flops. One extra flop on sclk/cs_n gives
//    rise/fall detect. MOSI is delayed identically so it aligns with the detected SCLK edge.
//  - Frame = 16 bits MSB first: bit15 RW (1=read), bits14:8 ADDR, bits7:0 DATA.
//  - The CS_N falling edge clears bit_cnt and shift. SCLK edges are ignored while CS_N is high.
//  - SCLK rising (CS_N low, bit_cnt<16): shift <= {shift[14:0],mosi}, bit_cnt++.
//  - The counter saturates at 16. Further SCLK edges in the same CS window are ignored.
//  - Commit happens in the clk cycle after the 16th rising edge is detected:
//      RW=0, ADDR=0: seg_reg <= DATA. RW=0, ADDR=1: ctrl_reg <= DATA.
//      Any other ADDR, or RW=1: no register change.
//      frame_valid pulses for every 16-bit frame, including ignored addresses.
//  - seg_out is registered one clk after the register update:
//      ctrl[0]=1: seg_out <= seg_reg ^ {8{ctrl[1]}}.
//      ctrl[0]=0: seg_out <= {8{ctrl[1]}} (blank for either polarity).
//    ctrl[7:2] are stored and read back but have no function.
//  - Readback: on the clk after the 8th rising edge, if RW=1, load tx <= reg[ADDR] (0x00 for
//    unknown ADDR) and spi_miso <= tx[7]. Each following SCLK fall shifts the next bit out.
//    With RW=0, or during bits 0..7, spi_miso=0.
//  - CS_N rising: if 0<bit_cnt<16, frame_err pulses and nothing is written. If bit_cnt=16, no pulse.
//    In all cases spi_miso=0, spi_miso_oe=0, bit_cnt=0.
//  - Simultaneous CS_N rise and 16th SCLK rise in the same clk cycle: CS_N wins, giving frame_err
//    and no commit.
//  - frame_valid and frame_err are never high in the same cycle.
// STRUCTURE
//  - Package spi_seg_pkg: FRAME_BITS=16, ADDR_SEG=7'h00, ADDR_CTRL=7'h01, CTRL_EN_BIT=0,
//    CTRL_INV_BIT=1, SEG_BLANK=8'h00.
//  - Sub-module spi_sync_edge: SYNC_STAGES synchroniser plus rise/fall detect. One instance each for
//    sclk and cs_n; mosi uses its synchroniser output only.
//  - Top body: bit counter, shift/tx registers, register file, output stage. No explicit FSM beyond
//    bit_cnt (IDLE = CS_N high, SHIFT = 0..15, DONE = 16).
// TESTING  (clk=50 MHz, SCLK=1 MHz unless noted)
//  1. Reset held 4 clk, SPI idle -> seg_out=8'h00, spi_miso=0, spi_miso_oe=0; no pulses.
//  2. Write frame 16'h003F -> one frame_valid pulse; seg_out=8'h3F two clk after the 16th SCLK
//     rise is detected.
//  3. Write 16'h0103 after test 2 -> seg_out=8'hC0. Then write 16'h0102 -> seg_out=8'hFF.
//     Then write 16'h0100 -> seg_out=8'h00.
//  4. Read frame 16'h8000 with seg_reg=8'h3F -> MISO bits 8..15 = 0,0,1,1,1,1,1,1; frame_valid
//     pulses; seg_reg unchanged. Read 16'h8500 -> MISO data 8'h00.
//  5. CS_N raised after 10 bits of 16'h00AA -> one frame_err pulse, no frame_valid, seg_out
//     unchanged. The next frame 16'h0055 writes correctly.
//  6. rst_n low for 1 clk after bit 9 of a write, then a full 16'h0077 frame -> seg_out=8'h77.
//     Also: a 20-bit burst starting 16'h0011 -> seg_out=8'h11 and extra bits ignored.
//     Also: SCLK at clk/8 -> still decoded correctly.

Source files
------------

// File: rtl/spi_segment_rx_pkg.sv
// -----------------------------------------------------------------------------
// spi_seg_pkg
// Shared constants and helpers for the SPI segment receiver.
//   FRAME_BITS      : bits per SPI frame (RW + 7-bit ADDR + 8-bit DATA)
//   ADDR_SEG/CTRL   : register addresses of the segment and control registers
//   CTRL_*_BIT      : control register bit positions
//   SEG_BLANK       : segment pattern for a blanked, non-inverted display
//   frame_phase_e   : receiver phase derived from CS_N and the bit counter
//   seg_drive()     : maps segment + control registers to the segment bus
// -----------------------------------------------------------------------------
package spi_seg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = 5;

  localparam logic [6:0] ADDR_SEG  = 7'h00;
  localparam logic [6:0] ADDR_CTRL = 7'h01;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_INV_BIT = 1;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Bit counter landmarks: value held before the bit is taken.
  localparam logic [CNT_W-1:0] CNT_HDR_LAST = CNT_W'(7);   // 8th bit completes RW+ADDR
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL     = CNT_W'(FRAME_BITS);
  // First falling edge that advances readback data (falls after rises 9..15).
  localparam logic [CNT_W-1:0] CNT_TX_FIRST = CNT_W'(9);

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,  // CS_N high or frame not armed
    PH_SHIFT = 2'd1,  // 0..15 bits received
    PH_DONE  = 2'd2   // 16 bits received, further edges ignored
  } frame_phase_e;

  // Enabled: pattern, optionally inverted. Disabled: blank at the chosen polarity.
  function automatic logic [7:0] seg_drive(input logic [7:0] seg, input logic [7:0] ctrl);
    logic [7:0] pol;
    pol = {8{ctrl[CTRL_INV_BIT]}};
    if (ctrl[CTRL_EN_BIT]) begin
      return seg ^ pol;
    end
    return SEG_BLANK ^ pol;
  endfunction

endpackage

// File: rtl/spi_segment_rx_if.sv
// -----------------------------------------------------------------------------
// spi_segment_rx_if
// Bundles the SPI pins and the decoded outputs of the segment receiver.
//   spi_sclk/spi_cs_n/spi_mosi : SPI master -> receiver (asynchronous)
//   spi_miso/spi_miso_oe       : readback data and its output enable
//   seg_out                    : registered segment drive {dp,g,f,e,d,c,b,a}
//   frame_valid/frame_err      : one-clock status pulses
// Modports: master = SPI host side, slave = receiver side.
// -----------------------------------------------------------------------------
interface spi_segment_rx_if;

  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] seg_out;
  logic       frame_valid;
  logic       frame_err;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi,
    input  spi_miso, spi_miso_oe, seg_out, frame_valid, frame_err
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi,
    output spi_miso, spi_miso_oe, seg_out, frame_valid, frame_err
  );

endinterface

// File: rtl/spi_segment_rx_sync_edge.sv
// -----------------------------------------------------------------------------
// spi_sync_edge
// Multi-flop synchroniser for one asynchronous input plus edge detection.
//   clk      in  system clock
//   rst_n    in  synchronous active-low reset (chain clears to 0)
//   i_async  in  asynchronous input
//   o_sync   out synchronised level (SYNC_STAGES clocks of latency)
//   o_rise   out 1 in the first cycle o_sync is high
//   o_fall   out 1 in the first cycle o_sync is low
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [SYNC_STAGES-1:0] w_sync_next;
  logic                   r_dly;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        assign w_sync_next[gi] = i_async;
      end else begin : g_rest
        assign w_sync_next[gi] = r_sync[gi-1];
      end
    end
  endgenerate

  // Chain clears to 0: after reset a low input produces no edge, so a CS_N
  // already held low is never mistaken for the start of a new frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= w_sync_next;
      r_dly  <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_rise = o_sync & ~r_dly;
  assign o_fall = ~o_sync & r_dly;

endmodule

// File: rtl/spi_segment_rx.sv
// -----------------------------------------------------------------------------
// spi_segment_rx
// SPI mode-0 slave that decodes 16-bit frames {RW, ADDR[6:0], DATA[7:0]} into
// a segment register (ADDR 0) and a control register (ADDR 1), drives a
// registered segment bus and returns register contents on MISO for reads.
//   clk    in  system clock, at least 8x SCLK
//   rst_n  in  synchronous active-low reset
//   bus    slave modport of spi_segment_rx_if (SPI pins, seg_out, pulses)
// Parameters: SYNC_STAGES (>=2), SEG_RST, CTRL_RST register reset values.
// -----------------------------------------------------------------------------
module spi_segment_rx
  import spi_seg_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] SEG_RST     = 8'h00,
  parameter logic [7:0] CTRL_RST    = 8'h01
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_segment_rx_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Input synchronisation
  // ---------------------------------------------------------------------------
  logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
  logic w_cs_sync, w_cs_rise, w_cs_fall;
  logic w_unused_sclk_level;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(bus.spi_sclk),
    .o_sync (w_sclk_sync),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(bus.spi_cs_n),
    .o_sync (w_cs_sync),
    .o_rise (w_cs_rise),
    .o_fall (w_cs_fall)
  );

  // Only SCLK edges matter; its level is not used.
  assign w_unused_sclk_level = w_sclk_sync;

  // MOSI takes the same number of stages as SCLK, so when a rising edge is
  // flagged the MOSI sample beside it is the bit the master set up for it.
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] w_mosi_next;
  logic                   w_mosi;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_mosi
      if (gi == 0) begin : g_first
        assign w_mosi_next[gi] = bus.spi_mosi;
      end else begin : g_rest
        assign w_mosi_next[gi] = r_mosi_sync[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mosi_sync <= '0;
    end else begin
      r_mosi_sync <= w_mosi_next;
    end
  end

  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // Receiver state
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] r_bit_cnt;
  logic [15:0]      r_shift;
  logic             r_in_frame;     // armed by a CS_N fall seen since reset
  logic             r_load_pend;    // header complete, load readback next cycle
  logic             r_commit_pend;  // 16 bits complete, commit next cycle
  logic [7:0]       r_seg;
  logic [7:0]       r_ctrl;
  logic [6:0]       r_tx;           // remaining readback bits, MSB next
  logic             r_miso;
  logic             r_miso_oe;
  logic [7:0]       r_seg_out;
  logic             r_frame_valid;
  logic             r_frame_err;

  frame_phase_e w_phase;
  logic         w_bit_take;
  logic         w_tx_shift;
  logic         w_short_frame;
  logic [7:0]   w_rd_data;

  // Header view while bits 8..15 are still arriving: shift[7:0] = {RW, ADDR}.
  logic       w_hdr_rw;
  logic [6:0] w_hdr_addr;
  // Full-frame view once 16 bits are in.
  logic       w_frm_rw;
  logic [6:0] w_frm_addr;
  logic [7:0] w_frm_data;

  assign w_hdr_rw   = r_shift[7];
  assign w_hdr_addr = r_shift[6:0];
  assign w_frm_rw   = r_shift[15];
  assign w_frm_addr = r_shift[14:8];
  assign w_frm_data = r_shift[7:0];

  always_comb begin
    w_phase = PH_IDLE;
    if (r_in_frame) begin
      w_phase = (r_bit_cnt == CNT_FULL) ? PH_DONE : PH_SHIFT;
    end
  end

  // A CS_N edge in the same cycle overrides any SCLK edge, so a 16th rise
  // coinciding with CS_N rising never commits.
  assign w_bit_take    = w_sclk_rise && (w_phase == PH_SHIFT) && !w_cs_rise && !w_cs_fall;
  assign w_tx_shift    = w_sclk_fall && (w_phase == PH_SHIFT) && (r_bit_cnt >= CNT_TX_FIRST);
  assign w_short_frame = w_cs_rise && (w_phase == PH_SHIFT) && (r_bit_cnt != '0);

  always_comb begin
    w_rd_data = 8'h00;
    case (w_hdr_addr)
      ADDR_SEG:  w_rd_data = r_seg;
      ADDR_CTRL: w_rd_data = r_ctrl;
      default:   w_rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_in_frame    <= 1'b0;
      r_load_pend   <= 1'b0;
      r_commit_pend <= 1'b0;
      r_seg         <= SEG_RST;
      r_ctrl        <= CTRL_RST;
      r_tx          <= '0;
      r_miso        <= 1'b0;
      r_miso_oe     <= 1'b0;
      r_seg_out     <= 8'h00;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_load_pend   <= 1'b0;
      r_commit_pend <= 1'b0;

      if (w_cs_fall) begin
        r_in_frame <= 1'b1;
        r_bit_cnt  <= '0;
        r_shift    <= '0;
        r_tx       <= '0;
        r_miso     <= 1'b0;
      end else if (w_cs_rise) begin
        r_in_frame  <= 1'b0;
        r_bit_cnt   <= '0;
        r_miso      <= 1'b0;
        r_frame_err <= w_short_frame;
      end else begin
        if (w_bit_take) begin
          r_shift       <= {r_shift[14:0], w_mosi};
          r_bit_cnt     <= r_bit_cnt + 1'b1;
          r_load_pend   <= (r_bit_cnt == CNT_HDR_LAST);
          r_commit_pend <= (r_bit_cnt == CNT_LAST);
        end
        if (r_load_pend) begin
          if (w_hdr_rw) begin
            r_tx   <= w_rd_data[6:0];
            r_miso <= w_rd_data[7];
          end
        end else if (w_tx_shift) begin
          r_tx   <= {r_tx[5:0], 1'b0};
          r_miso <= r_tx[6];
        end
      end

      // The frame is already complete here, so a CS_N rise in this cycle
      // does not cancel it.
      if (r_commit_pend) begin
        r_frame_valid <= 1'b1;
        if (!w_frm_rw) begin
          case (w_frm_addr)
            ADDR_SEG:  r_seg  <= w_frm_data;
            ADDR_CTRL: r_ctrl <= w_frm_data;
            default:   ;
          endcase
        end
      end

      r_miso_oe <= !w_cs_sync && (r_in_frame || w_cs_fall);
      r_seg_out <= seg_drive(r_seg, r_ctrl);
    end
  end

  assign bus.spi_miso    = r_miso;
  assign bus.spi_miso_oe = r_miso_oe;
  assign bus.seg_out     = r_seg_out;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_err   = r_frame_err;

endmodule
